regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the xgriscv pipeline. It is the next generation of the single-write, dual-read register file and sits between decode (operand read) and writeback. It adds:
- configurable numbers of read and write ports;
- posedge writes with deterministic write-port priority;
- optional same-cycle write-to-read bypass;
- a sequential clear engine that zeroes the array after reset or on request.

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 45 ++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and FSM encodings for the multi-port register file.
// Optional same-cycle write-to-read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_mp_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear engine: walks cidx over registers 1..NREGS-1 after reset or a clr pulse.
module regfile_clear_seq
    import regfile_mp_pkg::*;
#(
    parameter int  NREGS = RF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state;
    logic [AW-1:0] cidx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RF_CLEAR;
            cidx  <= AW'(1);
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr) begin
                        state <= RF_CLEAR;
                        cidx  <= AW'(1);
                    end
                end
                RF_CLEAR: begin
                    // clr is ignored here; leaving at the last index means cidx never wraps
                    if (cidx == AW'(NREGS - 1)) state <= RF_IDLE;
                    else                        cidx  <= cidx + AW'(1);
                end
                default: state <= RF_CLEAR;
            endcase
        end
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cidx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR prioritised write ports, NRD combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int  XLEN  = RF_XLEN,
    parameter int  NREGS = RF_NREGS,
    parameter int  NRD   = 2,
    parameter int  NWR   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                clr,
    output logic                busy,
    input  logic [AW-1:0]       reg_sel,
    output logic [XLEN-1:0]     reg_data
);

    logic [NRD-1:0][AW-1:0]   ra_v;
    logic [NRD-1:0][XLEN-1:0] rd_v;
    logic [NWR-1:0][AW-1:0]   wa_v;
    logic [NWR-1:0][XLEN-1:0] wd_v;

    assign ra_v = ra;
    assign wa_v = wa;
    assign wd_v = wd;
    assign rd   = rd_v;

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_clear_seq #(.NREGS(NREGS)) u_clr (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Entry 0 exists only to keep indexing simple; it is never written or read.
    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_addr] <= '0;
        end else begin
            // Ascending loop: the last (highest) matching port's assignment wins.
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa_v[p] != '0) rf[wa_v[p]] <= wd_v[p];
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] val;
        always_comb begin
            val = '0;
            if (!busy && ra_v[i] != '0) begin
                val = rf[ra_v[i]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NWR; p++) begin
                    if (we[p] && wa_v[p] != '0 && wa_v[p] == ra_v[i]) val = wd_v[p];
                end
`endif
            end
        end
        assign rd_v[i] = val;
    end

    assign reg_data = (busy || reg_sel == '0) ? '0 : rf[reg_sel];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=2, NWR=2); follows REGFILE_BYPASS_EN if defined.
module tb_regfile_mp;

    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic                clk = 1'b0, rstn = 1'b1, clr = 1'b0;
    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*XLEN-1:0] rd;
    logic [NWR-1:0]      we = '0;
    logic [NWR*AW-1:0]   wa = '0;
    logic [NWR*XLEN-1:0] wd = '0;
    logic                busy;
    logic [AW-1:0]       reg_sel = '0;
    logic [XLEN-1:0]     reg_data;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rstn(rstn), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .clr(clr), .busy(busy), .reg_sel(reg_sel), .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: contents plus remaining clear cycles; the array is zeroed when the clear finishes.
    logic [XLEN-1:0] mdl [NREGS];
    int busy_cnt = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_cnt <= NREGS - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) for (int r = 0; r < NREGS; r++) mdl[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (we[p] && wa[p*AW +: AW] != '0) mdl[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
            if (clr) busy_cnt <= NREGS - 1;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input int i);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] e;
        a = ra[i*AW +: AW];
        if (busy_cnt > 0 || a == '0) return '0;
        e = mdl[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p*AW +: AW] != '0 && wa[p*AW +: AW] == a) e = wd[p*XLEN +: XLEN];
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", XLEN'(busy), XLEN'(busy_cnt > 0));
            for (int i = 0; i < NRD; i++) chk($sformatf("rd%0d", i), rd[i*XLEN +: XLEN], exp_rd(i));
            chk("reg_data", reg_data,
                (busy_cnt > 0 || reg_sel == '0) ? '0 : mdl[reg_sel]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we[p]              = 1'b1;
        wa[p*AW +: AW]     = a;
        wd[p*XLEN +: XLEN] = d;
    endtask

    task automatic cnt_busy(inout int n);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1'b1;
        end
    endtask

    task automatic all_zero(input string nm);
        for (int r = 0; r < NREGS; r++) begin
            step();
            reg_sel = AW'(r);
            @(negedge clk);
            chk(nm, reg_data, 32'h0);
        end
    endtask

    int n;

    initial begin
        // Reset then clear
        #1 rstn = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", XLEN'(busy), 32'h1);
        chk("rst_rd0", rd[31:0], 32'h0);
        step();
        rstn = 1'b1;
        n = 0;
        cnt_busy(n);
        chk("rst_clear_len", n, 32'd31);
        all_zero("post_rst_zero");

        // Basic write/read
        step();
        wr(0, 5'd5, 32'hDEADBEEF);
        ra[0 +: AW] = 5'd5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("x5_wr_cycle", rd[31:0], 32'hDEADBEEF);
`else
        chk("x5_wr_cycle", rd[31:0], 32'h0);
`endif
        step();
        we = '0;
        @(negedge clk);
        chk("x5_read", rd[31:0], 32'hDEADBEEF);

        // Write to x0 is dropped
        step();
        wr(0, 5'd0, 32'h1234);
        ra[0 +: AW] = 5'd0;
        reg_sel = 5'd0;
        step();
        we = '0;
        @(negedge clk);
        chk("x0_rd", rd[31:0], 32'h0);
        chk("x0_dbg", reg_data, 32'h0);

        // Same-address conflict: higher port wins
        step();
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        step();
        we = '0;
        ra[AW +: AW] = 5'd7;
        reg_sel = 5'd7;
        @(negedge clk);
        chk("x7_conflict_rd1", rd[63:32], 32'h22);
        chk("x7_conflict_dbg", reg_data, 32'h22);

        // Same-cycle write/read of x9
        step();
        wr(0, 5'd9, 32'hA5A5);
        ra[AW +: AW] = 5'd9;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("x9_bypass", rd[63:32], 32'hA5A5);
`else
        chk("x9_old", rd[63:32], 32'h0);
`endif
        step();
        we = '0;
        @(negedge clk);
        chk("x9_next", rd[63:32], 32'hA5A5);

        // Fill x1..x31 with own index
        for (int r = 1; r < NREGS; r++) begin
            step();
            we = '0;
            wr(0, AW'(r), XLEN'(r));
        end
        step();
        we = '0;
        reg_sel = 5'd17;
        ra[0 +: AW] = 5'd30;
        @(negedge clk);
        chk("fill_x17", reg_data, 32'd17);
        chk("fill_x30", rd[31:0], 32'd30);

        // Clear request with writes attempted during busy
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr(0, 5'd3, 32'hFF);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) n++;
        end
        step();
        we = '0;
        cnt_busy(n);
        chk("clr_len", n, 32'd31);
        step();
        ra[0 +: AW] = 5'd3;
        @(negedge clk);
        chk("x3_cleared", rd[31:0], 32'h0);
        all_zero("post_clr_zero");

        // Reset in the middle of a clear restarts it in full
        step();
        wr(0, 5'd31, 32'h77);
        step();
        we = '0;
        reg_sel = 5'd31;
        @(negedge clk);
        chk("x31_pre", reg_data, 32'h77);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (9) step();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        n = 0;
        cnt_busy(n);
        chk("midclr_len", n, 32'd31);
        step();
        reg_sel = 5'd31;
        @(negedge clk);
        chk("x31_post", reg_data, 32'h0);

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
